// File: rtl/writeback_unit.sv
// writeback_unit
// Write-back stage of the interpolation ASIP. It accepts one retiring
// instruction per cycle and drives the register-file write port.
// ALU results commit one cycle after accept. Loads are assembled from
// WORD_W-bit memory beats: 1 beat for a scalar load and VEC_WORDS beats
// for a vector load. Upstream is held off while a load is being collected.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid / in_ready  retiring-instruction handshake
//   WriteRegister        instruction writes a scalar register
//   WriteRegisterVec     instruction writes a vector register (wins over scalar)
//   SelWriteData         0 = ALU result, 1 = memory load
//   rd                   destination register index
//   alu_result           ALU / vector-unit result
//   mem_word, mem_valid  load beat from data memory
//   WRITEREGISTER_WB     scalar write strobe
//   WRITEREGISTERVEC_WB  vector write strobe
//   RD_WB, INPUTDATA     write index and write data
//   stall                inverse of in_ready, freezes the upstream pipeline
//   mem_err              sticky: a memory beat arrived with no load pending
module writeback_unit #(
  parameter int WORD_W    = 32,
  parameter int VEC_WORDS = 8,
  parameter int RD_W      = 5
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        WriteRegister,
  input  logic                        WriteRegisterVec,
  input  logic                        SelWriteData,
  input  logic [RD_W-1:0]             rd,
  input  logic [WORD_W*VEC_WORDS-1:0] alu_result,
  input  logic [WORD_W-1:0]           mem_word,
  input  logic                        mem_valid,
  output logic                        WRITEREGISTER_WB,
  output logic                        WRITEREGISTERVEC_WB,
  output logic [RD_W-1:0]             RD_WB,
  output logic [WORD_W*VEC_WORDS-1:0] INPUTDATA,
  output logic                        stall,
  output logic                        mem_err
);

  localparam int DATA_W = WORD_W * VEC_WORDS;
  localparam int CNT_W  = $clog2(VEC_WORDS + 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COLLECT = 2'd1;
  localparam logic [1:0] COMMIT  = 2'd2;

  logic [1:0]        state_r;
  logic [1:0]        state_nxt_s;
  logic [CNT_W-1:0]  cnt_r;
  logic              kind_vec_r;
  logic              kind_sc_r;
  logic [RD_W-1:0]   rd_r;
  logic [DATA_W-1:0] data_r;
  logic              mem_err_r;
  logic              ready_s;
  logic              accept_s;
  logic              writes_s;
  logic              last_beat_s;

  // A no-op (neither kind bit) is accepted but leaves the write port untouched.
  assign writes_s = WriteRegister | WriteRegisterVec;

  // Scalar loads need a single beat, so every captured beat is the last one.
  assign last_beat_s = kind_vec_r ? (cnt_r == CNT_W'(VEC_WORDS - 1)) : 1'b1;

  // Next-state and handshake decode
  always_comb begin
    state_nxt_s = state_r;
    ready_s     = 1'b1;
    accept_s    = 1'b0;
    case (state_r)
      IDLE, COMMIT: begin
        ready_s  = 1'b1;
        accept_s = in_valid;
        if (in_valid) begin
          if (!writes_s) begin
            state_nxt_s = IDLE;
          end else if (SelWriteData) begin
            state_nxt_s = COLLECT;
          end else begin
            state_nxt_s = COMMIT;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      COLLECT: begin
        ready_s  = 1'b0;
        accept_s = 1'b0;
        if (mem_valid && last_beat_s) begin
          state_nxt_s = COMMIT;
        end else begin
          state_nxt_s = COLLECT;
        end
      end
      default: begin
        ready_s     = 1'b1;
        accept_s    = 1'b0;
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, latched instruction, assembled data and sticky error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      cnt_r      <= {CNT_W{1'b0}};
      kind_vec_r <= 1'b0;
      kind_sc_r  <= 1'b0;
      rd_r       <= {RD_W{1'b0}};
      data_r     <= {DATA_W{1'b0}};
      mem_err_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      // Beats are only legal while collecting; the accept cycle itself counts as stray.
      if (mem_valid && (state_r != COLLECT)) begin
        mem_err_r <= 1'b1;
      end
      if (accept_s && writes_s) begin
        rd_r       <= rd;
        kind_vec_r <= WriteRegisterVec;
        kind_sc_r  <= WriteRegister & ~WriteRegisterVec;
        cnt_r      <= {CNT_W{1'b0}};
        if (SelWriteData) begin
          data_r <= {DATA_W{1'b0}};
        end else if (WriteRegisterVec) begin
          data_r <= alu_result;
        end else begin
          data_r <= DATA_W'(alu_result[WORD_W-1:0]);
        end
      end else if ((state_r == COLLECT) && mem_valid) begin
        for (int i = 0; i < VEC_WORDS; i++) begin
          if (cnt_r == CNT_W'(i)) begin
            data_r[i*WORD_W +: WORD_W] <= mem_word;
          end
        end
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end
  end

  assign in_ready            = ready_s;
  assign stall               = ~ready_s;
  assign WRITEREGISTER_WB    = (state_r == COMMIT) & kind_sc_r;
  assign WRITEREGISTERVEC_WB = (state_r == COMMIT) & kind_vec_r;
  assign RD_WB               = rd_r;
  assign INPUTDATA           = data_r;
  assign mem_err             = mem_err_r;

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: directed scenarios followed by
// random traffic, all compared against a transaction-level reference model.
module tb_writeback_unit;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic         WriteRegister;
  logic         WriteRegisterVec;
  logic         SelWriteData;
  logic [4:0]   rd;
  logic [255:0] alu_result;
  logic [31:0]  mem_word;
  logic         mem_valid;
  logic         WRITEREGISTER_WB;
  logic         WRITEREGISTERVEC_WB;
  logic [4:0]   RD_WB;
  logic [255:0] INPUTDATA;
  logic         stall;
  logic         mem_err;

  int total = 0;
  int bad   = 0;

  // reference model state
  bit           m_collect;
  int           m_need;
  int           m_got;
  logic [31:0]  m_lanes [8];
  logic [4:0]   m_rd;
  bit           m_vec;
  logic [255:0] m_data;
  bit           m_commit;
  bit           m_err;
  bit           m_known;

  writeback_unit dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .WriteRegister(WriteRegister), .WriteRegisterVec(WriteRegisterVec),
    .SelWriteData(SelWriteData), .rd(rd), .alu_result(alu_result),
    .mem_word(mem_word), .mem_valid(mem_valid),
    .WRITEREGISTER_WB(WRITEREGISTER_WB), .WRITEREGISTERVEC_WB(WRITEREGISTERVEC_WB),
    .RD_WB(RD_WB), .INPUTDATA(INPUTDATA), .stall(stall), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock cycle: check current outputs, drive inputs, advance the model.
  task automatic cyc(input logic r, input logic v, input logic wr, input logic wrv,
                     input logic sel, input logic [4:0] d, input logic [255:0] alu,
                     input logic mv, input logic [31:0] mw);
    chk("in_ready", in_ready, !m_collect);
    chk("stall", stall, m_collect);
    chk("wr_scalar", WRITEREGISTER_WB, m_commit && !m_vec);
    chk("wr_vector", WRITEREGISTERVEC_WB, m_commit && m_vec);
    chk("mem_err", mem_err, m_err);
    if (m_commit || m_known) begin
      chk("rd_wb", RD_WB, m_rd);
      chk("inputdata", INPUTDATA, m_data);
    end

    rst = r; in_valid = v; WriteRegister = wr; WriteRegisterVec = wrv;
    SelWriteData = sel; rd = d; alu_result = alu; mem_valid = mv; mem_word = mw;

    if (r) begin
      m_collect = 0; m_commit = 0; m_err = 0; m_rd = '0; m_data = '0; m_known = 1;
    end else begin
      bit nxt_commit = 0;
      if (m_collect) begin
        if (mv) begin
          m_lanes[m_got] = mw;
          m_got++;
          if (m_got == m_need) begin
            m_collect = 0;
            nxt_commit = 1;
            m_data = '0;
            for (int i = 0; i < m_need; i++) m_data[32*i +: 32] = m_lanes[i];
          end
        end
      end else begin
        if (mv) m_err = 1;
        if (v && (wr || wrv)) begin
          m_known = 0;
          m_rd = d;
          m_vec = wrv;
          if (!sel) begin
            m_data = wrv ? alu : {224'd0, alu[31:0]};
            nxt_commit = 1;
          end else begin
            m_collect = 1;
            m_need = wrv ? 8 : 1;
            m_got = 0;
          end
        end
      end
      m_commit = nxt_commit;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 256'd0, 1'b0, 32'd0);
  endtask

  task automatic beat(input logic [31:0] w);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 256'd0, 1'b1, w);
  endtask

  initial begin
    logic [255:0] ones;
    logic [255:0] ra;
    ones = '1;

    // bring DUT out of unknown state before checking
    rst = 1'b1; in_valid = 1'b0; WriteRegister = 1'b0; WriteRegisterVec = 1'b0;
    SelWriteData = 1'b0; rd = 5'd0; alu_result = 256'd0; mem_word = 32'd0; mem_valid = 1'b0;
    m_collect = 0; m_commit = 0; m_err = 0; m_rd = '0; m_data = '0; m_known = 1;
    m_vec = 0; m_need = 0; m_got = 0;
    @(negedge clk); @(negedge clk);

    // 1: ALU scalar write, upper bits must be cleared
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 256'd0, 1'b0, 32'd0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd3, {ones[255:32], 32'h0000_00AB}, 1'b0, 32'd0);
    chk("t1_strobe", WRITEREGISTER_WB, 1'b1);
    chk("t1_data", INPUTDATA, 256'h0000_00AB);
    idle(2);

    // 2: back-to-back ALU vector writes
    for (int i = 1; i <= 3; i++)
      cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'(i), {8{32'(i * 32'h0101_0101)}}, 1'b0, 32'd0);
    idle(2);

    // 3: vector load to rd=7 with a 2-cycle gap between beats 3 and 4
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd7, 256'd0, 1'b0, 32'd0);
    for (int i = 0; i < 8; i++) begin
      if (i == 4) idle(2);
      beat(32'h1111_1111 * (i + 1));
    end
    chk("t3_lane0", INPUTDATA[31:0], 32'h1111_1111);
    chk("t3_lane7", INPUTDATA[255:224], 32'h8888_8888);
    idle(1);

    // 4: scalar load, then stray beat sets the sticky error
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd9, 256'd0, 1'b0, 32'd0);
    beat(32'hDEAD_BEEF);
    chk("t4_data", INPUTDATA, 256'hDEAD_BEEF);
    idle(1);
    beat(32'h0BAD_0BAD);
    idle(3);
    chk("t4_sticky", mem_err, 1'b1);

    // 5: reset in the middle of a vector load, then a normal ALU write
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 256'd0, 1'b0, 32'd0);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd12, 256'd0, 1'b0, 32'd0);
    for (int i = 0; i < 4; i++) beat(32'hC000_0000 + 32'(i));
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 256'd0, 1'b0, 32'd0);
    idle(1);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd4, {8{32'h1234_5678}}, 1'b0, 32'd0);
    idle(1);

    // 6: both kind bits (vector wins), then a no-op
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, {8{32'hA5A5_5A5A}}, 1'b0, 32'd0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd6, {8{32'h7777_7777}}, 1'b0, 32'd0);
    idle(2);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      logic rr, vv, mvv;
      for (int k = 0; k < 8; k++) ra[32*k +: 32] = $urandom;
      rr  = ($urandom_range(0, 59) == 0);
      vv  = ($urandom_range(0, 9) < 6);
      mvv = m_collect ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 39) == 0);
      cyc(rr, vv, 1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom), ra, mvv, $urandom);
    end
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/writeback_unit.md
Name: writeback_unit

Overview:
Write-back stage of the interpolation ASIP. It drives the register-file write port used by instruction decode: WRITEREGISTER_WB, WRITEREGISTERVEC_WB, RD_WB and INPUTDATA. It accepts one retiring instruction per cycle from the memory stage. ALU results are registered and committed directly. Loads are assembled from 32-bit memory beats; a vector load collects 8 beats into one 256-bit write. The unit stalls upstream while a load is being assembled.

Parameters:
WORD_W, 32, width of one memory beat and of a scalar register
VEC_WORDS, 8, beats per vector load; the INPUTDATA width is WORD_W*VEC_WORDS
RD_W, 5, destination register index width

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
in_valid  in  1  retiring instruction present
in_ready  out  1  unit can accept an instruction this cycle
WriteRegister  in  1  instruction writes a scalar register
WriteRegisterVec  in  1  instruction writes a vector register
SelWriteData  in  1  write-data source: 0 = ALU result, 1 = memory load
rd  in  RD_W  destination register index
alu_result  in  WORD_W*VEC_WORDS  ALU/vector-unit result
mem_word  in  WORD_W  load beat from data memory
mem_valid  in  1  mem_word is valid this cycle
WRITEREGISTER_WB  out  1  scalar register-file write strobe
WRITEREGISTERVEC_WB  out  1  vector register-file write strobe
RD_WB  out  RD_W  write index
INPUTDATA  out  WORD_W*VEC_WORDS  write data
stall  out  1  equals !in_ready; drives the upstream pipeline freeze
mem_err  out  1  sticky: mem_valid arrived while no load was pending

Behaviour:
- Reset: state IDLE, beat counter 0, every output 0, except in_ready=1 and stall=0. Reset during COLLECT discards the partial load; no write is issued.
- States: IDLE, COLLECT, COMMIT. in_ready=1 in IDLE and in COMMIT, 0 in COLLECT.
- Accept: an instruction is accepted when in_valid & in_ready. On accept the unit latches rd and the write kind.
  - Write kind is vector if WriteRegisterVec=1; this wins when both kind bits are set, and the scalar strobe is suppressed.
  - Write kind is scalar if only WriteRegister=1.
  - If neither bit is set, the instruction is a no-op: it is accepted and the next state is IDLE.
- Accept with SelWriteData=0:
  - Latch alu_result; the next state is COMMIT.
  - For a scalar write, INPUTDATA[WORD_W-1:0]=alu_result low word and the upper bits are 0. For a vector write, INPUTDATA is the full alu_result.
  - Latency is 1 cycle from accept to strobe.
- Accept with SelWriteData=1:
  - Clear the data register and the counter; the next state is COLLECT.
  - The target beat count is 1 for a scalar write and VEC_WORDS for a vector write.
  - mem_valid in the accept cycle is not captured.
- COLLECT:
  - Each cycle with mem_valid=1 writes mem_word into lane cnt (bits [WORD_W*cnt+WORD_W-1 : WORD_W*cnt]) and increments cnt. Beat 0 goes to lane 0.
  - Cycles with mem_valid=0 hold state; there is no timeout.
  - When the beat with cnt==target-1 is captured, the next state is COMMIT.
  - Scalar-load upper bits stay 0.
- COMMIT (exactly 1 cycle per write):
  - Assert WRITEREGISTER_WB or WRITEREGISTERVEC_WB according to the latched kind.
  - RD_WB shows the latched rd; INPUTDATA shows the assembled data.
  - A new accept in this same cycle follows the IDLE accept rules. An ALU accept gives COMMIT again, so back-to-back ALU writes sustain 1 write per cycle. A load accept gives COLLECT. No accept gives IDLE.
- Strobes are high only in COMMIT; both are never high together.
- RD_WB and INPUTDATA hold their last committed values while the strobes are low. They change only on an accept or on a COLLECT capture.
- mem_err is set when mem_valid=1 in IDLE or in COMMIT (including the cycle a load is accepted). It is cleared only by rst.
- rd=0 is passed through unchanged; register 0 semantics belong to the register file.

Test Plan:
1. Reset, then an ALU scalar write: accept with rd=3, alu_result low word 0x0000_00AB and upper bits 0xFF..F. Next cycle: WRITEREGISTER_WB=1, RD_WB=3, INPUTDATA=0x...0000_00AB with upper bits 0; cycle after: strobe 0.
2. Back-to-back ALU vector writes: rd=1, 2, 3 in consecutive cycles. Expect WRITEREGISTERVEC_WB=1 for 3 consecutive cycles with RD_WB=1, 2, 3, and in_ready=1 throughout.
3. Vector load to rd=7: mem beats 0x11111111 through 0x88888888, with mem_valid low for 2 cycles between beats 3 and 4. Expect stall=1 during collection. After the 8th beat, a 1-cycle WRITEREGISTERVEC_WB with INPUTDATA[31:0]=0x11111111 and INPUTDATA[255:224]=0x88888888.
4. Scalar load to rd=9, beat 0xDEADBEEF. Expect WRITEREGISTER_WB 1 cycle after the beat, INPUTDATA=0x...DEADBEEF with upper bits 0. Also assert a stray mem_valid in IDLE and check mem_err=1 and sticky until rst.
5. Vector load with rst asserted after 4 beats. Expect no strobe, all outputs 0, in_ready=1. A following ALU write commits normally.
6. Both WriteRegister and WriteRegisterVec set, ALU source: only WRITEREGISTERVEC_WB pulses. Neither set: no strobe, and in_ready stays 1.
